// File: rtl/score_tracker.sv
// Score, high-score and length keeper plus the game-state FSM.
// Reacts to the one-cycle goodColl/badColl pulses and to start_i. Every output
// comes from a register or is a direct decode of the state register.
module score_tracker #(
  parameter int DIGITS     = 2,
  parameter int INIT_LEN   = 2,
  parameter int MAX_LENGTH = 50,
  parameter int LEN_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  goodColl,
  input  logic                  badColl,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hi_score,
  output logic [LEN_W-1:0]      length,
  output logic [1:0]            state,
  output logic                  grow,
  output logic                  game_over
);

  localparam int SW = 4 * DIGITS;
  localparam logic [LEN_W-1:0] C_INIT_LEN = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(MAX_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_LOSE = 2'b10,
    ST_WIN  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [SW-1:0]    r_score;
  logic [SW-1:0]    w_score_next;
  logic [SW-1:0]    r_hi_score;
  logic [LEN_W-1:0] r_length;
  logic [LEN_W-1:0] w_length_next;
  logic [LEN_W-1:0] w_length_inc;
  logic             r_grow;
  logic             w_grow_next;

  // BCD incrementer: a carry ripples through every digit that is currently 9.
  // The carry out of the top digit is only set when all digits are 9, which is
  // exactly the saturation condition.
  logic [DIGITS:0]  w_carry;
  logic [SW-1:0]    w_score_inc;
  logic             w_score_all_nine;

  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_digit;
      logic       w_is_nine;
      assign w_digit   = r_score[4*gi +: 4];
      assign w_is_nine = (w_digit == 4'd9);
      assign w_score_inc[4*gi +: 4] = !w_carry[gi] ? w_digit :
                                      (w_is_nine ? 4'd0 : w_digit + 4'd1);
      assign w_carry[gi+1] = w_carry[gi] & w_is_nine;
    end
  endgenerate

  assign w_score_all_nine = w_carry[DIGITS];
  assign w_length_inc     = r_length + LEN_W'(1);

  // Next-state and next-datapath decode for the game FSM.
  always_comb begin
    w_state_next  = r_state;
    w_score_next  = r_score;
    w_length_next = r_length;
    w_grow_next   = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (badColl) begin
          // A wall/self hit wins over an apple in the same cycle.
          w_state_next = ST_LOSE;
        end else if (goodColl) begin
          if (!w_score_all_nine) begin
            w_score_next = w_score_inc;
          end
          w_length_next = w_length_inc;
          w_grow_next   = 1'b1;
          if (w_length_inc == C_MAX_LEN) begin
            w_state_next = ST_WIN;
          end
        end
      end
      default: begin
        // IDLE, LOSE and WIN all wait for a start pulse and ignore collisions.
        if (start_i) begin
          w_state_next  = ST_PLAY;
          w_score_next  = '0;
          w_length_next = C_INIT_LEN;
        end
      end
    endcase
  end

  // State, score, length and grow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_score  <= '0;
      r_length <= C_INIT_LEN;
      r_grow   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_score  <= w_score_next;
      r_length <= w_length_next;
      r_grow   <= w_grow_next;
    end
  end

  // High score follows the registered score one cycle later. With valid BCD
  // digits packed MSD-high, an unsigned compare of the whole vector orders the
  // same way as a digit-by-digit compare starting at the most significant digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_score <= '0;
    end else if (r_score > r_hi_score) begin
      r_hi_score <= r_score;
    end
  end

  assign score     = r_score;
  assign hi_score  = r_hi_score;
  assign length    = r_length;
  assign state     = r_state;
  assign grow      = r_grow;
  assign game_over = (r_state == ST_LOSE) || (r_state == ST_WIN);

endmodule
